// File: rtl/hsv_core_pkg.sv
// Shared core types for the issue-stage register file and its writeback path.
package hsv_core_pkg;

  typedef logic [4:0]  reg_addr;
  typedef logic [31:0] word;

  typedef struct packed {
    reg_addr rd;
    word     data;
  } wb_req_t;

  localparam int WB_SRC_ALU    = 0;
  localparam int WB_SRC_BRANCH = 1;
  localparam int WB_SRC_MEM    = 2;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hsv_core_writeback_arbiter_if.sv
// Result-source handshakes plus the regfile write port; master is the arbiter side.
interface hsv_core_writeback_arbiter_if
  import hsv_core_pkg::*;
#(
  parameter int N_SRC = 3
) ();

  logic [N_SRC-1:0] src_valid;
  logic [N_SRC-1:0] src_ready;
  reg_addr          src_rd   [N_SRC];
  word              src_data [N_SRC];

  logic             wr_en;
  reg_addr          wr_addr;
  word              wr_data;

  modport master (
    input  src_valid, src_rd, src_data,
    output src_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output src_valid, src_rd, src_data,
    input  src_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/hsv_core_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, modulo N.
module hsv_core_rr_arbiter
  import hsv_core_pkg::*;
#(
  parameter int  N  = 3,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/hsv_core_writeback_arbiter.sv
// Round-robin writeback arbiter driving the regfile write port from a registered stage.
// Optional retired-write counter output wb_count is enabled by HSV_CORE_WB_COUNT_EN.
module hsv_core_writeback_arbiter
  import hsv_core_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic clk_core,
  input  logic rst,
  input  logic flush,
  hsv_core_writeback_arbiter_if.master bus
`ifdef HSV_CORE_WB_COUNT_EN
  ,
  output logic [63:0] wb_count
`endif
);

  localparam int PW = ptr_width(N_SRC);

  logic [PW-1:0]    r_rr_ptr;
  logic             r_wr_en;
  reg_addr          r_wr_addr;
  word              r_wr_data;

  logic [N_SRC-1:0] w_req;
  logic [N_SRC-1:0] w_grant;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  wb_req_t          w_sel;
  logic             w_wr_en_next;

  // Reset is folded in here so ready drops as soon as rst rises, not at the next edge.
  assign w_req = (flush || rst) ? '0 : bus.src_valid;

  hsv_core_rr_arbiter #(
    .N(N_SRC)
  ) u_rr (
    .req  (w_req),
    .ptr  (r_rr_ptr),
    .grant(w_grant),
    .idx  (w_idx)
  );

  assign w_any         = |w_grant;
  assign bus.src_ready = w_grant;
  assign w_sel         = '{rd: bus.src_rd[w_idx], data: bus.src_data[w_idx]};
  assign w_wr_en_next  = w_any && (w_sel.rd != '0);

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_wr_en_next;
      if (w_any) begin
        r_wr_addr <= w_sel.rd;
        r_wr_data <= w_sel.data;
        r_rr_ptr  <= (w_idx == PW'(N_SRC - 1)) ? '0 : w_idx + PW'(1);
      end
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

`ifdef HSV_CORE_WB_COUNT_EN
  logic [63:0] r_wb_count;

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      r_wb_count <= '0;
    end else if (w_wr_en_next) begin
      r_wb_count <= r_wb_count + 64'd1;
    end
  end

  assign wb_count = r_wb_count;
`endif

endmodule

// File: tb/tb_hsv_core_writeback_arbiter.sv
// Directed bench for hsv_core_writeback_arbiter: stimulus pushes expected writes, a monitor pops them.
module tb_hsv_core_writeback_arbiter;
  import hsv_core_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  hsv_core_writeback_arbiter_if #(.N_SRC(3)) bus ();

`ifdef HSV_CORE_WB_COUNT_EN
  logic [63:0] wb_count;
`endif

  hsv_core_writeback_arbiter #(.N_SRC(3)) dut (
    .clk_core(clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus)
`ifdef HSV_CORE_WB_COUNT_EN
    ,
    .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  word     rf [32];
  wb_req_t exp_q [$];
  wb_req_t mon_e;
  int      n_checks  = 0;
  int      n_err     = 0;
  int      n_exp_wr  = 0;

  always @(posedge clk) begin
    if (!rst && bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      $display("write: addr=%0d data=%h", bus.wr_addr, bus.wr_data);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(mon_e.rd));
        chk("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
      end
    end
  end

  task automatic step(input string name, input logic [2:0] v,
                      input reg_addr r0, input reg_addr r1, input reg_addr r2,
                      input word d0, input word d1, input word d2,
                      input logic [2:0] exp_rdy);
    reg_addr rs [3];
    word     ds [3];
    rs = '{r0, r1, r2};
    ds = '{d0, d1, d2};
    bus.src_valid   = v;
    bus.src_rd[0]   = r0;
    bus.src_rd[1]   = r1;
    bus.src_rd[2]   = r2;
    bus.src_data[0] = d0;
    bus.src_data[1] = d1;
    bus.src_data[2] = d2;
    #1;
    chk({name, "_ready"}, 64'(bus.src_ready), 64'(exp_rdy));
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i] && rs[i] != '0) begin
        exp_q.push_back('{rd: rs[i], data: ds[i]});
        n_exp_wr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  reg_addr    fair_rd  [6][3];
  logic [2:0] fair_exp [6];

  initial begin
    fair_rd  = '{'{5'd5, 5'd6, 5'd7}, '{5'd8, 5'd6, 5'd7}, '{5'd8, 5'd9, 5'd7},
                 '{5'd8, 5'd9, 5'd10}, '{5'd11, 5'd9, 5'd10}, '{5'd11, 5'd12, 5'd10}};
    fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset held with every source valid.
    bus.src_valid   = 3'b111;
    bus.src_rd[0]   = 5'd1;
    bus.src_rd[1]   = 5'd2;
    bus.src_rd[2]   = 5'd3;
    bus.src_data[0] = 32'h1111_0001;
    bus.src_data[1] = 32'h2222_0002;
    bus.src_data[2] = 32'h3333_0003;
    #2;
    chk("reset_ready",   64'(bus.src_ready), 64'd0);
    chk("reset_wr_en",   64'(bus.wr_en),     64'd0);
    chk("reset_wr_addr", 64'(bus.wr_addr),   64'd0);
    chk("reset_wr_data", 64'(bus.wr_data),   64'd0);
`ifdef HSV_CORE_WB_COUNT_EN
    chk("reset_wb_count", wb_count, 64'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_hold_ready", 64'(bus.src_ready), 64'd0);
    rst = 1'b0;

    step("rst_release", 3'b111, 5'd1, 5'd2, 5'd3, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 3'b001);

    // Single write then regfile readback of x3.
    step("single", 3'b001, 5'd3, 5'd0, 5'd0, 32'hdeadbeef, 32'h0, 32'h0, 3'b001);
    chk("single_wr_en", 64'(bus.wr_en), 64'd1);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
    chk("rf_rs1_x3", 64'(rf[3]), 64'hdeadbeef);

    // x0 write from source 1 is accepted but not written.
    step("x0", 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hcafebabe, 32'h0, 3'b010);
    chk("x0_wr_en", 64'(bus.wr_en), 64'd0);
`ifdef HSV_CORE_WB_COUNT_EN
    chk("x0_wb_count", wb_count, 64'(n_exp_wr));
`endif
    step("after_x0", 3'b111, 5'd13, 5'd14, 5'd15, 32'hd, 32'he, 32'hf, 3'b100);

    // Fairness: all valid, each source re-presents a new rd after acceptance.
    for (int k = 0; k < 6; k++) begin
      step("fair", 3'b111, fair_rd[k][0], fair_rd[k][1], fair_rd[k][2],
           32'h100 + 32'(fair_rd[k][0]), 32'h100 + 32'(fair_rd[k][1]),
           32'h100 + 32'(fair_rd[k][2]), fair_exp[k]);
    end

    // Flush blocks grants for two cycles; pointer stays at 0.
    flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step("flush", 3'b101, 5'd20, 5'd0, 5'd21, 32'h20, 32'h0, 32'h21, 3'b000);
      chk("flush_wr_en", 64'(bus.wr_en), 64'd0);
    end
    flush = 1'b0;
    step("post_flush", 3'b101, 5'd20, 5'd0, 5'd21, 32'h20, 32'h0, 32'h21, 3'b001);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);

    // Reset while a write is in flight drops it immediately.
    bus.src_valid = 3'b001;
    bus.src_rd[0] = 5'd7;
    bus.src_data[0] = 32'h7777_7777;
    @(posedge clk);
    #1;
    chk("midop_wr_en_before", 64'(bus.wr_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("midop_wr_en",   64'(bus.wr_en),     64'd0);
    chk("midop_wr_addr", 64'(bus.wr_addr),   64'd0);
    chk("midop_ready",   64'(bus.src_ready), 64'd0);
`ifdef HSV_CORE_WB_COUNT_EN
    chk("midop_wb_count", wb_count, 64'd0);
`endif
    bus.src_valid = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Five nonzero writes and two x0 writes.
    step("cnt", 3'b001, 5'd1, 5'd0, 5'd0, 32'h5000_0001, 32'h0, 32'h0, 3'b001);
    step("cnt", 3'b010, 5'd0, 5'd2, 5'd0, 32'h0, 32'h5000_0002, 32'h0, 3'b010);
    step("cnt", 3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h5000_0003, 3'b100);
    step("cnt", 3'b001, 5'd4, 5'd0, 5'd0, 32'h5000_0004, 32'h0, 32'h0, 3'b001);
    step("cnt", 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h5000_0005, 32'h0, 3'b010);
    step("cnt", 3'b100, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h5000_0006, 3'b100);
    step("cnt", 3'b001, 5'd6, 5'd0, 5'd0, 32'h5000_0007, 32'h0, 32'h0, 3'b001);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
`ifdef HSV_CORE_WB_COUNT_EN
    chk("wb_count", wb_count, 64'd5);
`endif
    chk("rf_x6", 64'(rf[6]), 64'h5000_0007);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
